comp_pipe_hs: RTL
=================

Name: comp_pipe_hs

Overview:
- Parametrised, handshaked successor to the team's registered bitwise compute blocks; processes WIDTH-bit vectors a, b, c bit-parallel through a fixed 2-stage pipeline.
- Per-beat mode select: mode 0 gives the difference/borrow pair; mode 1 gives the full-adder sum/carry pair.
- Supports valid/ready backpressure, a busy flag and a saturating output-beat counter.
- Sits between producer and consumer datapath stages that both use valid/ready.

Parameters:
- WIDTH, 8, bit width of a, b, c, d, f (min 1).
- CNT_W, 16, width of beat_cnt (min 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts input this cycle.
- mode  input  1  function select, sampled with the input beat.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- c  input  WIDTH  operand c.
- out_valid  output  1  d/f valid.
- out_ready  input  1  consumer accepts output.
- d  output  WIDTH  result d.
- f  output  WIDTH  result f.
- busy  output  1  either pipeline stage holds a beat.
- cnt_clr  input  1  synchronous clear of beat_cnt.
- beat_cnt  output  CNT_W  number of output handshakes, saturating.

Behaviour:
- Single clock. Reset is asynchronous and active-low: clk and rst_n; assertion acts immediately, release is synchronous to clk.
- Reset values:
  - v1 = v2 = 0, so out_valid = 0 and busy = 0.
  - d = f = 0, beat_cnt = 0, all stage registers = 0.
  - in_ready is forced to 0 while rst_n is low.
- Stage 1 register loads on input handshake (in_valid & in_ready):
  - a1 = a; x1 = b ^ c; m1 = mode.
  - g1 = mode ? (b & c) : (~b & c).
- Stage 2 register loads when stage 1 advances:
  - d = a1 ^ x1.
  - f = g1 | (a1 & (m1 ? x1 : ~x1)).
- Resulting functions:
  - mode 0: d = a^b^c, f = (~b&c) | (~(b^c)&a).
  - mode 1: d = a^b^c, f = (b&c) | (a&(b^c)).
- Handshake:
  - adv2 = ~v2 | out_ready.
  - in_ready = ~v1 | adv2 (combinational; no combinational path from in_valid).
  - Stage 1 content moves to stage 2 when v1 & adv2.
  - v2 clears on output handshake if no new beat enters.
- Latency and throughput:
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready stays high.
  - Throughput is 1 beat per cycle.
- Stall:
  - While out_valid & ~out_ready, d/f/out_valid are held stable.
  - Stage 1 still fills if empty. With both stages full, in_ready = 0.
  - No beat is dropped or duplicated; order is preserved.
- busy = v1 | v2.
- beat_cnt:
  - Increments on out_valid & out_ready.
  - Saturates at all-ones; no wrap.
  - cnt_clr wins over a simultaneous handshake: result is 0 and that beat is not counted.
- Reset mid-operation: in-flight beats are discarded, all state returns to reset values, and no out_valid pulse follows.
- Output d/f are don't-care when out_valid = 0 but keep their last registered value; the bench must not check them then.

Decomposition:
- Shared package comp_pkg:
  - localparams MODE_BORROW = 1'b0 and MODE_CARRY = 1'b1.
  - Default WIDTH/CNT_W constants.
- One natural sub-module: comp_pipe_stage, a generic valid/ready register slice (payload width parameter). It is instantiated twice, with the bitwise logic between the slices.
- The counter stays inline.

Test Plan:
- Reset and idle: rst_n = 0 for 3 cycles, then release with in_valid = 0 -> out_valid = 0, d = f = 0, beat_cnt = 0, busy = 0, in_ready = 1 after release.
- Mode 0 (WIDTH = 4): a = 1010, b = 1100, c = 0110, out_ready = 1 -> 2 cycles later out_valid = 1, d = 0000, f = 0010, beat_cnt = 1.
- Mode 1, same operands -> d = 0000, f = 1110. Also sweep all 512 combinations for WIDTH = 3 in both modes against the reference model.
- Backpressure: stream 4 beats with out_ready = 0 -> in_ready drops after 2 accepted, d/f stay stable. Then raise out_ready -> remaining beats emerge in order, back-to-back, with no loss.
- Counter: CNT_W = 2, 5 output handshakes -> beat_cnt = 3 (saturated). cnt_clr asserted together with a handshake -> beat_cnt = 0.
- Reset mid-stream: assert rst_n low while both stages are valid -> out_valid falls immediately, busy = 0. After release, no stale beat appears.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared constants for the handshaked bitwise compute pipeline.
package comp_pkg;

    // Function select values carried with each input beat.
    localparam logic MODE_BORROW = 1'b0;
    localparam logic MODE_CARRY  = 1'b1;

    // Default datapath and beat-counter widths.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/comp_pipe_stage.sv
// Generic valid/ready register slice: one payload register plus its valid flag.
// Accepts a new beat whenever it is empty or its current beat leaves this cycle.
module comp_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v;
    logic [W-1:0] q;

    assign in_ready  = ~v | out_ready;
    assign out_valid = v;
    assign out_data  = q;

    // Load on input handshake, otherwise drain when downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            q <= '0;
        end else if (in_valid && in_ready) begin
            v <= 1'b1;
            q <= in_data;
        end else if (out_ready) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/comp_pipe_hs.sv
// Two-stage handshaked bitwise compute block: difference/borrow (mode 0) or
// full-adder sum/carry (mode 1), with busy flag and saturating beat counter.
module comp_pipe_hs
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] f,
    output logic             busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int unsigned P1_W = 3 * WIDTH + 1;
    localparam int unsigned P2_W = 2 * WIDTH;

    logic             s1_ready;
    logic             v1;
    logic [P1_W-1:0]  p1_in;
    logic [P1_W-1:0]  p1_q;
    logic             s2_ready;
    logic             v2;
    logic [P2_W-1:0]  p2_in;
    logic [P2_W-1:0]  p2_q;

    logic [WIDTH-1:0] g0;
    logic             m1;
    logic [WIDTH-1:0] g1;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] d_nxt;
    logic [WIDTH-1:0] f_nxt;

    // Stage 1 payload: generate term and propagate term precomputed from b, c.
    always_comb begin
        g0    = (mode == MODE_CARRY) ? (b & c) : (~b & c);
        p1_in = {mode, g0, b ^ c, a};
    end

    comp_pipe_stage #(.W(P1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   (p1_in),
        .out_valid (v1),
        .out_ready (s2_ready),
        .out_data  (p1_q)
    );

    // Stage 2 payload: final d/f from the stage 1 terms.
    always_comb begin
        {m1, g1, x1, a1} = p1_q;
        d_nxt = a1 ^ x1;
        f_nxt = g1 | (a1 & (m1 ? x1 : ~x1));
        p2_in = {f_nxt, d_nxt};
    end

    comp_pipe_stage #(.W(P2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (s2_ready),
        .in_data   (p2_in),
        .out_valid (v2),
        .out_ready (out_ready),
        .out_data  (p2_q)
    );

    assign in_ready  = rst_n & s1_ready;
    assign out_valid = v2;
    assign {f, d}    = p2_q;
    assign busy      = v1 | v2;

    // Saturating count of output handshakes; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (cnt_clr) begin
            beat_cnt <= '0;
        end else if (v2 && out_ready && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
